stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - fixed: an external sel picks the source, the same way a 2:1 mux does.
  - round-robin: the block arbitrates fairly among the valid inputs.
- The output is registered, with 1-cycle latency and full 1-word/cycle throughput.
- Sits between several producers and one consumer, and replaces ad-hoc mux instances in the datapath.

Parameters:
- NCH, 4, number of input channels (2..16).
- WIDTH, 4, data width per channel in bits (>=1).
- CW, $clog2(NCH), width of the channel index. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  CW  source channel in fixed mode; ignored in round-robin mode.
- in_valid  input  NCH  per-channel valid; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel ready (combinational); one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  registered data.
- out_chan  output  CW  index of the channel that produced out_data.

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. While rst_n=0:
  - out_valid=0, out_data=0, out_chan=0.
  - rr pointer=0.
  - in_ready=0 (forced combinationally).
- Reset mid-transfer drops the held word; no input handshake completes in that cycle.
- Load condition: load = !out_valid | out_ready.
- Grant (combinational, only when load=1 and rst_n=1):
  - fixed mode: grant channel sel if in_valid[sel]=1; if sel>=NCH, no grant.
  - round-robin mode: grant the first channel with in_valid set, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (modulo NCH).
- in_ready[g]=1 only for the granted channel g; all other bits are 0. An input handshake occurs when in_valid[i] & in_ready[i].
- On a handshake:
  - next cycle: out_data=in_data[g], out_chan=g, out_valid=1.
  - round-robin mode only: ptr <= (g+1) mod NCH, wrapping NCH-1 -> 0.
- Load with no grant: out_valid <= 0. out_data/out_chan hold their old value (don't-care).
- Load=0 (out_valid=1, out_ready=0): the output register holds; all in_ready=0.
- Simultaneous output consume and new input grant in one cycle gives back-to-back words with no bubble.
- Fixed mode never changes ptr.
- Mode or sel changes take effect at the next arbitration. A word already in the output register is unaffected.
- Latency: input handshake in cycle n -> out_valid in cycle n+1.
- Producers must hold in_data stable while in_valid=1 and not granted. The block does not check this.

Decomposition:
- Package stream_mux_pkg:
  - constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - function for the channel-index width.
- Sub-module rr_arbiter (NCH parameter):
  - inputs: req[NCH], ptr[CW], en.
  - outputs: gnt one-hot [NCH], gnt_idx[CW], gnt_any.
  - purely combinational; the top level owns ptr.
- Top level holds the output register, load logic and the mode mux.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0000. Release; first round-robin grant is channel 0.
- Fixed mode, NCH=4, WIDTH=4: in_data={D,7,3,A}, all valid, out_ready=1.
  - sel=2 -> in_ready=0100; next cycle out_data=7, out_chan=2.
  - sel=0 -> out_data=A.
- Round-robin, all 4 valid, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, no bubbles. Then only ch1 and ch3 valid -> alternates 1,3,1,3.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_chan stable and in_ready=0000. Raise out_ready -> the next word loads in the same cycle.
- Wrap and sparse:
  - ptr=3, only ch3 valid -> grant 3, ptr wraps to 0.
  - next only ch2 valid -> grant 2.
  - fixed sel=3 with in_valid[3]=0 -> out_valid falls to 0.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst_n=0 for 1 cycle -> word dropped, out_valid=0, ptr=0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_pkg: shared constants and helpers for the stream_mux_rr block.
//   MODE_FIXED / MODE_RR : values of the mode input
//   chan_w(n)            : channel-index width for n channels (at least 1 bit)
package stream_mux_pkg;
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR = 1'b1;
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: valid/ready handshake bundle between NCH producers and one consumer.
//   in_valid/in_data/in_ready : per-channel input handshakes, channel i at bits [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_chan/out_ready : registered output stream and source channel index
//   slave modport = the mux, master modport = the environment driving inputs and consuming output
interface stream_mux_rr_if import stream_mux_pkg::*; #(
   parameter int NCH = 4,
   parameter int WIDTH = 4,
   localparam int CW = chan_w(NCH)
);
   logic [NCH-1:0] in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0] in_ready;
   logic out_valid;
   logic out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0] out_chan;
   modport slave (
      input in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );
   modport master (
      output in_valid, in_data, out_ready,
      input in_ready, out_valid, out_data, out_chan
   );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter; the caller owns the pointer.
//   req     : request per channel
//   ptr     : highest-priority channel; search runs ptr, ptr+1, ... wrapping at NCH
//   en      : arbitration enable; no grant when low
//   gnt     : one-hot grant (zero when nothing granted)
//   gnt_idx : index of the granted channel
//   gnt_any : a grant was issued
module rr_arbiter import stream_mux_pkg::*; #(
   parameter int NCH = 4,
   localparam int CW = chan_w(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   input  logic           en,
   output logic [NCH-1:0] gnt,
   output logic [CW-1:0]  gnt_idx,
   output logic           gnt_any
);
   logic [CW:0] s;
   always_comb begin
      gnt = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      s = '0;
      for (int k = 0; k < NCH; k++) begin
         // one extra bit so ptr+k cannot overflow before the modulo-NCH wrap
         s = {1'b0, ptr} + (CW+1)'(k);
         if (s >= (CW+1)'(NCH)) s = s - (CW+1)'(NCH);
         if (en && !gnt_any && req[s[CW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = s[CW-1:0];
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NCH-to-1 stream mux with fixed or round-robin selection and a registered output.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   mode  : MODE_FIXED uses sel, MODE_RR arbitrates among valid inputs
//   sel   : source channel in fixed mode
//   bus   : stream_mux_rr_if slave (input handshakes, output register, out_chan)
module stream_mux_rr import stream_mux_pkg::*; #(
   parameter int NCH = 4,
   parameter int WIDTH = 4,
   localparam int CW = chan_w(NCH)
) (
   input logic clk,
   input logic rst_n,
   input logic mode,
   input logic [CW-1:0] sel,
   stream_mux_rr_if.slave bus
);
   logic load, fix_ok, arb_any, g_any;
   logic [NCH-1:0] arb_gnt;
   logic [CW-1:0] arb_idx, g_idx, ptr;
   logic [WIDTH-1:0] ch [NCH];
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign ch[i] = bus.in_data[i*WIDTH +: WIDTH];
   end
   // the output register can take a new word when empty or being drained this cycle
   assign load = !bus.out_valid | bus.out_ready;
   assign fix_ok = rst_n && load && ({1'b0, sel} < (CW+1)'(NCH)) && bus.in_valid[sel];
   rr_arbiter #(.NCH(NCH)) u_arb (
      .req(bus.in_valid),
      .ptr(ptr),
      .en(rst_n && load && mode == MODE_RR),
      .gnt(arb_gnt),
      .gnt_idx(arb_idx),
      .gnt_any(arb_any)
   );
   // a grant is only ever given to a valid channel, so g_any is the input handshake
   assign g_any = (mode == MODE_RR) ? arb_any : fix_ok;
   assign g_idx = (mode == MODE_RR) ? arb_idx : sel;
   assign bus.in_ready = (mode == MODE_RR) ? arb_gnt : (fix_ok ? NCH'(1) << sel : '0);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_chan <= '0;
         ptr <= '0;
      end else if (load) begin
         bus.out_valid <= g_any;
         if (g_any) begin
            bus.out_data <= ch[g_idx];
            bus.out_chan <= g_idx;
            if (mode == MODE_RR) ptr <= (g_idx == CW'(NCH-1)) ? '0 : g_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed self-checking bench for stream_mux_rr with NCH=4, WIDTH=4.
module tb_stream_mux_rr;
   import stream_mux_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   logic mode;
   logic [1:0] sel;
   int checks = 0;
   int errors = 0;
   logic [3:0] dat [4] = '{4'hA, 4'h3, 4'h7, 4'hD};
   stream_mux_rr_if #(.NCH(4), .WIDTH(4)) bus ();
   stream_mux_rr #(.NCH(4), .WIDTH(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mode(mode),
      .sel(sel),
      .bus(bus)
   );
   initial forever #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check_out(input string tag, input int c);
      check({tag, " valid"}, 32'(bus.out_valid), 1);
      check({tag, " chan"}, 32'(bus.out_chan), 32'(c));
      check({tag, " data"}, 32'(bus.out_data), 32'(dat[c]));
   endtask
   initial begin
      int seq [5] = '{0, 1, 2, 3, 0};
      int alt [4] = '{1, 3, 1, 3};
      rst_n = 1'b0;
      mode = MODE_RR;
      sel = 2'd0;
      bus.in_valid = 4'hF;
      bus.in_data = 16'hD73A;
      bus.out_ready = 1'b1;
      step();
      step();
      check("rst out_valid", 32'(bus.out_valid), 0);
      check("rst out_data", 32'(bus.out_data), 0);
      check("rst out_chan", 32'(bus.out_chan), 0);
      check("rst in_ready", 32'(bus.in_ready), 0);
      rst_n = 1'b1;
      #1;
      check("first rr grant", 32'(bus.in_ready), 4'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         check_out($sformatf("rr all %0d", i), seq[i]);
      end
      bus.in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         check_out($sformatf("rr alt %0d", i), alt[i]);
      end
      bus.out_ready = 1'b0;
      #1;
      check("bp in_ready", 32'(bus.in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("bp hold %0d", i), 3);
         check($sformatf("bp ready %0d", i), 32'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp release ready", 32'(bus.in_ready), 4'b0010);
      step();
      check_out("bp release", 1);
      bus.in_valid = 4'b0100;
      step();
      check_out("to ptr3", 2);
      bus.in_valid = 4'b1000;
      #1;
      check("wrap ready", 32'(bus.in_ready), 4'b1000);
      step();
      check_out("wrap grant", 3);
      bus.in_valid = 4'b1001;
      #1;
      check("ptr wrapped", 32'(bus.in_ready), 4'b0001);
      bus.in_valid = 4'b0100;
      #1;
      check("sparse ready", 32'(bus.in_ready), 4'b0100);
      step();
      check_out("sparse grant", 2);
      mode = MODE_FIXED;
      bus.in_valid = 4'hF;
      sel = 2'd2;
      #1;
      check("fix sel2 ready", 32'(bus.in_ready), 4'b0100);
      step();
      check_out("fix sel2", 2);
      sel = 2'd0;
      step();
      check_out("fix sel0", 0);
      sel = 2'd3;
      bus.in_valid = 4'b0111;
      #1;
      check("fix novalid ready", 32'(bus.in_ready), 0);
      step();
      check("fix novalid out_valid", 32'(bus.out_valid), 0);
      mode = MODE_RR;
      bus.in_valid = 4'hF;
      #1;
      check("fix kept ptr", 32'(bus.in_ready), 4'b1000);
      step();
      check_out("rr resume", 3);
      step();
      check_out("rr next", 0);
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid rst in_ready", 32'(bus.in_ready), 0);
      step();
      check("mid rst out_valid", 32'(bus.out_valid), 0);
      check("mid rst out_data", 32'(bus.out_data), 0);
      check("mid rst out_chan", 32'(bus.out_chan), 0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid = 4'b1001;
      #1;
      check("mid rst ptr", 32'(bus.in_ready), 4'b0001);
      step();
      check_out("after rst", 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
